// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the two-port SDRAM request arbiter.
// Imported by the arbiter top and its edge-detect helper.
package sdram_arb_pkg;

    localparam int NUM_PORTS   = 2;
    localparam int DEF_ADDR_W  = 24;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 1023;
    localparam int CNT_W       = 10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

endpackage

// File: rtl/sdram_rise_detect.sv
// One-cycle delayed copy of a level plus a rising-edge pulse.
// The pulse is combinational so it lines up with the input's first high cycle.
module sdram_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-client round-robin front end for sdram_controller3.
// One request in flight; completion is a rising edge of the matching strobe.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_write,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rsp_rdata,
    output logic              p0_rsp_error,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_write,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rsp_rdata,
    output logic              p1_rsp_error,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    output logic              req_read,
    output logic              req_write,
    input  logic [DATA_W-1:0] data_out,
    input  logic              data_valid,
    input  logic              write_complete
);

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    arb_state_t        state;
    arb_state_t        state_nx;
    logic              prio;
    logic              owner;
    logic              wr_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              dv_rise;
    logic              wc_rise;
    logic              grant;
    logic              accept;
    logic              done;
    logic              expired;

    sdram_rise_detect u_dv_rise (
        .clk  (CLOCK_50),
        .rst  (rst),
        .din  (data_valid),
        .rise (dv_rise)
    );

    sdram_rise_detect u_wc_rise (
        .clk  (CLOCK_50),
        .rst  (rst),
        .din  (write_complete),
        .rise (wc_rise)
    );

    // A lone requester wins outright; contention goes to prio.
    assign grant   = (p0_req_valid & p1_req_valid) ? prio : p1_req_valid;
    assign accept  = (state == IDLE) & ~rst & (p0_req_valid | p1_req_valid);
    assign done    = wr_q ? wc_rise : dv_rise;
    assign expired = (cnt == TO_CNT);

    assign address = addr_q;
    assign data_in = wdata_q;

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        p0_req_ready = 1'b0;
        p1_req_ready = 1'b0;
        req_read     = 1'b0;
        req_write    = 1'b0;
        p0_rsp_valid = 1'b0;
        p1_rsp_valid = 1'b0;
        p0_rsp_rdata = '0;
        p1_rsp_rdata = '0;
        p0_rsp_error = 1'b0;
        p1_rsp_error = 1'b0;
        unique case (state)
            IDLE: begin
                p0_req_ready = accept & ~grant;
                p1_req_ready = accept & grant;
                if (accept) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                req_write = wr_q;
                req_read  = ~wr_q;
                state_nx  = WAIT;
            end
            WAIT: begin
                if (done | expired) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                p0_rsp_valid = ~owner;
                p1_rsp_valid = owner;
                p0_rsp_rdata = owner ? '0 : rdata_q;
                p1_rsp_rdata = owner ? rdata_q : '0;
                p0_rsp_error = ~owner & err_q;
                p1_rsp_error = owner & err_q;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            prio    <= 1'b0;
            owner   <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        owner   <= grant;
                        wr_q    <= grant ? p1_req_write : p0_req_write;
                        addr_q  <= grant ? p1_req_addr : p0_req_addr;
                        wdata_q <= grant ? p1_req_wdata : p0_req_wdata;
                    end
                end
                ISSUE: begin
                    cnt     <= '0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
                WAIT: begin
                    if (done) begin
                        rdata_q <= wr_q ? '0 : data_out;
                        err_q   <= 1'b0;
                    end else if (expired) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    prio <= ~owner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter with a stub controller
// and a transaction-level model of arbitration order and memory contents.
module tb_sdram_port_arbiter;

    localparam int AW = 24;
    localparam int DW = 32;
    localparam int TO = 1023;

    logic          CLOCK_50 = 1'b0;
    logic          rst;
    logic          p0_req_valid, p0_req_ready, p0_req_write;
    logic [AW-1:0] p0_req_addr;
    logic [DW-1:0] p0_req_wdata, p0_rsp_rdata;
    logic          p0_rsp_valid, p0_rsp_error;
    logic          p1_req_valid, p1_req_ready, p1_req_write;
    logic [AW-1:0] p1_req_addr;
    logic [DW-1:0] p1_req_wdata, p1_rsp_rdata;
    logic          p1_rsp_valid, p1_rsp_error;
    logic [AW-1:0] address;
    logic [DW-1:0] data_in, data_out;
    logic          req_read, req_write, data_valid, write_complete;

    sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .CLOCK_50       (CLOCK_50),
        .rst            (rst),
        .p0_req_valid   (p0_req_valid),
        .p0_req_ready   (p0_req_ready),
        .p0_req_write   (p0_req_write),
        .p0_req_addr    (p0_req_addr),
        .p0_req_wdata   (p0_req_wdata),
        .p0_rsp_valid   (p0_rsp_valid),
        .p0_rsp_rdata   (p0_rsp_rdata),
        .p0_rsp_error   (p0_rsp_error),
        .p1_req_valid   (p1_req_valid),
        .p1_req_ready   (p1_req_ready),
        .p1_req_write   (p1_req_write),
        .p1_req_addr    (p1_req_addr),
        .p1_req_wdata   (p1_req_wdata),
        .p1_rsp_valid   (p1_rsp_valid),
        .p1_rsp_rdata   (p1_rsp_rdata),
        .p1_rsp_error   (p1_rsp_error),
        .address        (address),
        .data_in        (data_in),
        .req_read       (req_read),
        .req_write      (req_write),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .write_complete (write_complete)
    );

    typedef struct {
        int            c;
        logic [DW-1:0] d;
        logic          e;
    } rsp_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_acc = 0;
    int prio_m = 0;
    rsp_t rq0[$];
    rsp_t rq1[$];
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [DW-1:0] exp_mem [logic [AW-1:0]];

    int viol_rsp = 0, viol_strb = 0, strobes = 0;
    int ctl_mode = 0, lat = 3, sched_wc = -1, sched_dv = -1;
    int s_cyc = -1;
    logic s_wr, prev_strb = 1'b0;
    logic [AW-1:0] s_addr, rd_addr;
    logic [DW-1:0] s_data;

    always #10 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return {8'hA5, a};
    endfunction

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : init_word(a);
    endfunction

    // Stub controller plus output monitor; mode 1 never completes,
    // mode 2 fakes a write_complete before the real data_valid.
    initial begin
        data_valid = 1'b0;
        write_complete = 1'b0;
        data_out = '0;
        forever begin
            @(negedge CLOCK_50);
            if (p0_rsp_valid && p1_rsp_valid) viol_rsp++;
            if (p0_rsp_valid) rq0.push_back('{c: cyc, d: p0_rsp_rdata, e: p0_rsp_error});
            if (p1_rsp_valid) rq1.push_back('{c: cyc, d: p1_rsp_rdata, e: p1_rsp_error});
            if (req_read && req_write) viol_strb++;
            if ((req_read || req_write) && prev_strb) viol_strb++;
            prev_strb = req_read || req_write;
            data_valid = 1'b0;
            write_complete = 1'b0;
            if (cyc == sched_wc) write_complete = 1'b1;
            if (cyc == sched_dv) begin
                data_valid = 1'b1;
                data_out = mem.exists(rd_addr) ? mem[rd_addr] : init_word(rd_addr);
            end
            if (req_read || req_write) begin
                strobes++;
                s_cyc = cyc;
                s_wr = req_write;
                s_addr = address;
                s_data = data_in;
                if (req_write) mem[address] = data_in;
                else rd_addr = address;
                case (ctl_mode)
                    0: if (req_write) sched_wc = cyc + lat; else sched_dv = cyc + lat;
                    2: begin sched_wc = cyc + 2; sched_dv = cyc + 6; end
                    default: ;
                endcase
            end
        end
    end

    task automatic drive(input int port, input logic v, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (port == 0) begin
            p0_req_valid = v; p0_req_write = wr; p0_req_addr = a; p0_req_wdata = d;
        end else begin
            p1_req_valid = v; p1_req_write = wr; p1_req_addr = a; p1_req_wdata = d;
        end
    endtask

    task automatic issue(input int port, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int acc);
        int n = 0;
        acc = -1;
        drive(port, 1'b1, wr, a, d);
        #1;
        while (((port == 0) ? p0_req_ready : p1_req_ready) !== 1'b1 && n < 2000) begin
            @(negedge CLOCK_50);
            #1;
            n++;
        end
        if (n < 2000) begin
            acc = cyc;
            n_acc++;
        end
        @(negedge CLOCK_50);
        drive(port, 1'b0, 1'b0, '0, '0);
        #2;
    endtask

    task automatic wait_rsp(input int port, input int budget, output rsp_t r, output bit got);
        int n = 0;
        got = 0;
        r = '{c: -1, d: '0, e: 1'b0};
        while (!got && n < budget) begin
            if (port == 0 && rq0.size() > 0) begin r = rq0.pop_front(); got = 1; end
            else if (port == 1 && rq1.size() > 0) begin r = rq1.pop_front(); got = 1; end
            else begin @(negedge CLOCK_50); #2; n++; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        p0_req_valid = 1'b1;
        #1;
        checks++;
        if ({address, data_in} !== '0) begin
            errors++;
            $display("FAIL reset_bus: got %0h/%0h expected 0/0", address, data_in);
        end
        checks++;
        if ({req_read, req_write, p0_rsp_valid, p1_rsp_valid, p0_rsp_error, p1_rsp_error,
             p0_req_ready, p1_req_ready} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctl: got %b expected 00000000",
                     {req_read, req_write, p0_rsp_valid, p1_rsp_valid, p0_rsp_error,
                      p1_rsp_error, p0_req_ready, p1_req_ready});
        end
        checks++;
        if ({p0_rsp_rdata, p1_rsp_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_rdata: got %0h/%0h expected 0/0", p0_rsp_rdata, p1_rsp_rdata);
        end
        p0_req_valid = 1'b0;
        @(negedge CLOCK_50);
        rst = 1'b0;
        prio_m = 0;
        @(negedge CLOCK_50);
    endtask

    task automatic test_simultaneous(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        int acc[2];
        logic [AW-1:0] a[2];
        logic [DW-1:0] e[2];
        rsp_t r[2];
        bit g[2];
        int w, l;
        a[0] = a0;
        a[1] = a1;
        w = prio_m;
        l = 1 - w;
        e[0] = model_rd(a0);
        e[1] = model_rd(a1);
        prio_m = 1 - l;
        ctl_mode = 0;
        lat = $urandom_range(1, 5);
        fork
            issue(0, 1'b0, a0, '0, acc[0]);
            issue(1, 1'b0, a1, '0, acc[1]);
        join
        wait_rsp(0, 50, r[0], g[0]);
        wait_rsp(1, 50, r[1], g[1]);
        checks++;
        if (acc[w] < 0 || acc[l] != acc[w] + lat + 3) begin
            errors++;
            $display("FAIL simul_order: winner p%0d at %0d loser at %0d required %0d",
                     w, acc[w], acc[l], acc[w] + lat + 3);
        end
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (!g[p] || r[p].c != acc[p] + lat + 2 || r[p].d !== e[p] || r[p].e !== 1'b0) begin
                errors++;
                $display("FAIL simul_rsp p%0d: got %0b c=%0d d=%0h e=%b expected c=%0d d=%0h e=0",
                         p, g[p], r[p].c, r[p].d, r[p].e, acc[p] + lat + 2, e[p]);
            end
        end
    endtask

    task automatic test_write_read();
        int acc;
        rsp_t r;
        bit g;
        ctl_mode = 0;
        lat = 4;
        issue(0, 1'b1, 24'h001000, 32'hDEADBEEF, acc);
        exp_mem[24'h001000] = 32'hDEADBEEF;
        checks++;
        if (acc < 0 || s_cyc != acc + 1 || s_wr !== 1'b1 || s_addr !== 24'h001000
            || s_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_strobe: got cyc=%0d wr=%b a=%0h d=%0h expected cyc=%0d wr=1 a=1000 d=deadbeef",
                     s_cyc, s_wr, s_addr, s_data, acc + 1);
        end
        wait_rsp(0, 50, r, g);
        checks++;
        if (!g || r.c != acc + lat + 2 || r.e !== 1'b0 || r.d !== '0) begin
            errors++;
            $display("FAIL wr_rsp: got %0b c=%0d d=%0h e=%b expected c=%0d d=0 e=0",
                     g, r.c, r.d, r.e, acc + lat + 2);
        end
        lat = 2;
        issue(0, 1'b0, 24'h001000, '0, acc);
        checks++;
        if (acc < 0 || s_cyc != acc + 1 || s_wr !== 1'b0 || s_addr !== 24'h001000) begin
            errors++;
            $display("FAIL rd_strobe: got cyc=%0d wr=%b a=%0h expected cyc=%0d wr=0 a=1000",
                     s_cyc, s_wr, s_addr, acc + 1);
        end
        wait_rsp(0, 50, r, g);
        checks++;
        if (!g || r.c != acc + lat + 2 || r.e !== 1'b0 || r.d !== model_rd(24'h001000)) begin
            errors++;
            $display("FAIL rd_rsp: got %0b c=%0d d=%0h e=%b expected c=%0d d=deadbeef e=0",
                     g, r.c, r.d, r.e, acc + lat + 2);
        end
        prio_m = 1;
    endtask

    task automatic test_wrong_type();
        int acc;
        rsp_t r;
        bit g;
        ctl_mode = 2;
        issue(0, 1'b0, 24'h001000, '0, acc);
        wait_rsp(0, 50, r, g);
        checks++;
        if (!g || r.c != acc + 8 || r.d !== model_rd(24'h001000) || r.e !== 1'b0) begin
            errors++;
            $display("FAIL wrong_type: got %0b c=%0d d=%0h e=%b expected c=%0d d=%0h e=0",
                     g, r.c, r.d, r.e, acc + 8, model_rd(24'h001000));
        end
        repeat (4) @(negedge CLOCK_50);
        #2;
        checks++;
        if (rq0.size() + rq1.size() != 0) begin
            errors++;
            $display("FAIL wrong_type_extra: got %0d extra responses expected 0",
                     rq0.size() + rq1.size());
        end
        ctl_mode = 0;
        prio_m = 1;
    endtask

    task automatic test_timeout();
        int acc;
        rsp_t r;
        bit g;
        ctl_mode = 1;
        issue(1, 1'b0, 24'h000777, '0, acc);
        wait_rsp(1, TO + 50, r, g);
        checks++;
        if (!g || acc < 0 || r.c != acc + TO + 3 || r.e !== 1'b1 || r.d !== '0) begin
            errors++;
            $display("FAIL timeout_rsp: got %0b c=%0d d=%0h e=%b expected c=%0d d=0 e=1",
                     g, r.c, r.d, r.e, acc + TO + 3);
        end
        ctl_mode = 0;
        lat = 3;
        issue(0, 1'b1, 24'h000055, 32'h0BADF00D, acc);
        exp_mem[24'h000055] = 32'h0BADF00D;
        wait_rsp(0, 50, r, g);
        checks++;
        if (!g || acc < 0 || r.c != acc + lat + 2 || r.e !== 1'b0) begin
            errors++;
            $display("FAIL after_timeout: got %0b acc=%0d c=%0d e=%b expected c=%0d e=0",
                     g, acc, r.c, r.e, acc + lat + 2);
        end
        prio_m = 1;
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            int kind, first, second, p;
            int acc[2];
            bit wr[2];
            logic [AW-1:0] a[2];
            logic [DW-1:0] d[2], e[2];
            rsp_t r;
            bit g;
            kind = $urandom_range(0, 2);
            lat = $urandom_range(1, 6);
            ctl_mode = 0;
            for (int q = 0; q < 2; q++) begin
                wr[q] = 1'($urandom_range(0, 1));
                a[q] = 24'h002000 | AW'($urandom_range(0, 3));
                d[q] = $urandom;
                acc[q] = -1;
            end
            first = (kind == 2) ? prio_m : kind;
            second = (kind == 2) ? 1 - first : -1;
            for (int k = 0; k < 2; k++) begin
                p = (k == 0) ? first : second;
                if (p >= 0) begin
                    if (wr[p]) begin exp_mem[a[p]] = d[p]; e[p] = '0; end
                    else e[p] = model_rd(a[p]);
                    prio_m = 1 - p;
                end
            end
            if (kind == 2) begin
                fork
                    issue(0, wr[0], a[0], d[0], acc[0]);
                    issue(1, wr[1], a[1], d[1], acc[1]);
                join
            end else begin
                issue(kind, wr[kind], a[kind], d[kind], acc[kind]);
            end
            for (int k = 0; k < 2; k++) begin
                p = (k == 0) ? first : second;
                if (p >= 0) begin
                    wait_rsp(p, 50, r, g);
                    checks++;
                    if (!g || acc[p] < 0 || r.c != acc[p] + lat + 2 || r.d !== e[p] || r.e !== 1'b0) begin
                        errors++;
                        $display("FAIL rand%0d p%0d: got %0b c=%0d d=%0h e=%b expected c=%0d d=%0h e=0",
                                 it, p, g, r.c, r.d, r.e, acc[p] + lat + 2, e[p]);
                    end
                end
            end
            if (kind == 2) begin
                checks++;
                if (acc[second] != acc[first] + lat + 3) begin
                    errors++;
                    $display("FAIL rand%0d order: loser at %0d required %0d",
                             it, acc[second], acc[first] + lat + 3);
                end
            end
        end
    endtask

    task automatic test_reset_in_flight();
        int acc;
        rsp_t r;
        bit g;
        ctl_mode = 0;
        lat = 10;
        issue(0, 1'b0, 24'h001000, '0, acc);
        repeat (3) @(negedge CLOCK_50);
        rst = 1'b1;
        @(negedge CLOCK_50);
        rst = 1'b0;
        #1;
        checks++;
        if ({address, data_in} !== '0 || {req_read, req_write, p0_rsp_valid, p1_rsp_valid} !== 4'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got a=%0h d=%0h ctl=%b expected 0/0/0000",
                     address, data_in, {req_read, req_write, p0_rsp_valid, p1_rsp_valid});
        end
        prio_m = 0;
        repeat (15) @(negedge CLOCK_50);
        #2;
        checks++;
        if (rq0.size() + rq1.size() != 0) begin
            errors++;
            $display("FAIL midreset_stale: got %0d responses expected 0", rq0.size() + rq1.size());
        end
        lat = 3;
        issue(1, 1'b1, 24'h000010, 32'h12345678, acc);
        exp_mem[24'h000010] = 32'h12345678;
        checks++;
        if (acc < 0 || s_cyc != acc + 1 || s_wr !== 1'b1 || s_addr !== 24'h000010
            || s_data !== 32'h12345678) begin
            errors++;
            $display("FAIL midreset_wr_strobe: got cyc=%0d wr=%b a=%0h d=%0h expected cyc=%0d wr=1 a=10 d=12345678",
                     s_cyc, s_wr, s_addr, s_data, acc + 1);
        end
        wait_rsp(1, 50, r, g);
        checks++;
        if (!g || r.c != acc + lat + 2 || r.e !== 1'b0) begin
            errors++;
            $display("FAIL midreset_wr_rsp: got %0b c=%0d e=%b expected c=%0d e=0",
                     g, r.c, r.e, acc + lat + 2);
        end
        prio_m = 0;
    endtask

    task automatic test_invariants();
        checks++;
        if (viol_rsp != 0) begin
            errors++;
            $display("FAIL rsp_exclusive: got %0d overlaps expected 0", viol_rsp);
        end
        checks++;
        if (viol_strb != 0) begin
            errors++;
            $display("FAIL strobe_shape: got %0d violations expected 0", viol_strb);
        end
        checks++;
        if (strobes != n_acc) begin
            errors++;
            $display("FAIL strobe_count: got %0d strobes expected %0d", strobes, n_acc);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        @(negedge CLOCK_50);
        test_reset();
        test_simultaneous(24'h001001, 24'h001002);
        test_write_read();
        test_simultaneous(24'h001001, 24'h001002);
        test_wrong_type();
        test_timeout();
        test_random();
        test_reset_in_flight();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
